recon_ram_writer: RTL and testbench

RECON_RAM_WRITER -- requirements
Module: recon_ram_writer

---
 rtl/recon_ram_writer_pkg.sv | 21 ++
 rtl/recon_ram_writer_blk_addr_gen.sv | 51 +++++
 rtl/recon_ram_writer.sv | 123 ++++++++++++
 tb/tb_recon_ram_writer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recon_ram_writer_pkg.sv
// Shared plane codes, FSM encoding and row helper for the reconstructed-block RAM writer.
package recon_ram_writer_pkg;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam logic [1:0] LAST_ROW = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Row r of a packed 4x4 block; pixel 0 of the row sits in the low byte.
  function automatic logic [31:0] row_word(input logic [127:0] pix, input logic [1:0] r);
    return pix[{r, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/recon_ram_writer_blk_addr_gen.sv
// Combinational word address of row 0 of a 4x4 block and the plane stride.
module blk_addr_gen
  import recon_ram_writer_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic [1:0]        comp,
  input  logic [3:0]        idx,
  input  logic [6:0]        mb_x,
  input  logic [6:0]        mb_y,
  input  logic [6:0]        pic_width_in_mbs,
  input  logic [ADDR_W-1:0] y_base,
  input  logic [ADDR_W-1:0] cb_base,
  input  logic [ADDR_W-1:0] cr_base,
  output logic [ADDR_W-1:0] row0_addr,
  output logic [ADDR_W-1:0] stride
);

  logic [1:0]        bx;
  logic [1:0]        by;
  logic [ADDR_W-1:0] col_w;
  logic [ADDR_W-1:0] py;
  logic [ADDR_W-1:0] base;

  // col_w is the pixel column divided by 4, i.e. already in words.
  always_comb begin
    bx     = 2'd0;
    by     = 2'd0;
    col_w  = '0;
    py     = '0;
    stride = '0;
    base   = '0;
    if (comp == COMP_Y) begin
      bx     = {idx[2], idx[0]};
      by     = {idx[3], idx[1]};
      col_w  = (ADDR_W'(mb_x) << 2) + ADDR_W'(bx);
      py     = (ADDR_W'(mb_y) << 4) + (ADDR_W'(by) << 2);
      stride = ADDR_W'(pic_width_in_mbs) << 2;
      base   = y_base;
    end else begin
      bx     = {1'b0, idx[0]};
      by     = {1'b0, idx[1]};
      col_w  = (ADDR_W'(mb_x) << 1) + ADDR_W'(bx);
      py     = (ADDR_W'(mb_y) << 3) + (ADDR_W'(by) << 2);
      stride = ADDR_W'(pic_width_in_mbs) << 1;
      base   = (comp == COMP_CB) ? cb_base : cr_base;
    end
    row0_addr = base + py * stride + col_w;
  end

endmodule

// File: rtl/recon_ram_writer.sv
// Writes one reconstructed 4x4 block into the frame RAM as four 32-bit row writes.
module recon_ram_writer
  import recon_ram_writer_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              write_to_ram_start,
  input  logic [7:0]        sum_0,
  input  logic [7:0]        sum_1,
  input  logic [7:0]        sum_2,
  input  logic [7:0]        sum_3,
  input  logic [7:0]        sum_4,
  input  logic [7:0]        sum_5,
  input  logic [7:0]        sum_6,
  input  logic [7:0]        sum_7,
  input  logic [7:0]        sum_8,
  input  logic [7:0]        sum_9,
  input  logic [7:0]        sum_10,
  input  logic [7:0]        sum_11,
  input  logic [7:0]        sum_12,
  input  logic [7:0]        sum_13,
  input  logic [7:0]        sum_14,
  input  logic [7:0]        sum_15,
  input  logic [1:0]        comp,
  input  logic [3:0]        blk4x4_idx,
  input  logic [6:0]        mb_x,
  input  logic [6:0]        mb_y,
  input  logic [6:0]        pic_width_in_mbs,
  input  logic [ADDR_W-1:0] y_base,
  input  logic [ADDR_W-1:0] cb_base,
  input  logic [ADDR_W-1:0] cr_base,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [31:0]       ram_wr_data,
  input  logic              ram_wr_ack,
  output logic              write_to_ram_valid,
  output logic [1:0]        dbg_state
);

  // Handshake: a row is transferred on each rising edge where ena, ram_wr_en and
  // ram_wr_ack are all high; ram_wr_addr/ram_wr_data stay stable until that edge.

  state_t            state;
  logic [1:0]        row_cnt;
  logic [127:0]      pix_q;
  logic [ADDR_W-1:0] stride_q;
  logic [127:0]      pix_in;
  logic [ADDR_W-1:0] row0_addr;
  logic [ADDR_W-1:0] stride;

  assign pix_in = {sum_15, sum_14, sum_13, sum_12, sum_11, sum_10, sum_9, sum_8,
                   sum_7,  sum_6,  sum_5,  sum_4,  sum_3,  sum_2,  sum_1, sum_0};

  blk_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .comp             (comp),
    .idx              (blk4x4_idx),
    .mb_x             (mb_x),
    .mb_y             (mb_y),
    .pic_width_in_mbs (pic_width_in_mbs),
    .y_base           (y_base),
    .cb_base          (cb_base),
    .cr_base          (cr_base),
    .row0_addr        (row0_addr),
    .stride           (stride)
  );

  // Block inputs are sampled only on the accepting start; later rows come from pix_q/stride_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      row_cnt            <= 2'd0;
      pix_q              <= '0;
      stride_q           <= '0;
      ram_wr_en          <= 1'b0;
      ram_wr_addr        <= '0;
      ram_wr_data        <= '0;
      write_to_ram_valid <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          write_to_ram_valid <= 1'b0;
          if (write_to_ram_start) begin
            pix_q       <= pix_in;
            stride_q    <= stride;
            row_cnt     <= 2'd0;
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= row0_addr;
            ram_wr_data <= row_word(pix_in, 2'd0);
            state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ram_wr_ack) begin
            if (row_cnt == LAST_ROW) begin
              ram_wr_en          <= 1'b0;
              write_to_ram_valid <= 1'b1;
              state              <= ST_DONE;
            end else begin
              row_cnt     <= row_cnt + 2'd1;
              ram_wr_addr <= ram_wr_addr + stride_q;
              ram_wr_data <= row_word(pix_q, row_cnt + 2'd1);
            end
          end
        end
        ST_DONE: begin
          write_to_ram_valid <= 1'b0;
          state              <= ST_IDLE;
        end
        default: begin
          ram_wr_en          <= 1'b0;
          write_to_ram_valid <= 1'b0;
          state              <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_recon_ram_writer.sv
// Scoreboard bench for recon_ram_writer: directed corner cases plus randomized blocks.
module tb_recon_ram_writer;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    sum [16];
  logic [1:0]    comp = 2'd0;
  logic [3:0]    idx = 4'd0;
  logic [6:0]    mb_x = 7'd0;
  logic [6:0]    mb_y = 7'd0;
  logic [6:0]    width = 7'd0;
  logic [AW-1:0] y_base = '0;
  logic [AW-1:0] cb_base = '0;
  logic [AW-1:0] cr_base = '0;
  logic          ack = 1'b1;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [31:0]   ram_wr_data;
  logic          valid;
  logic [1:0]    dbg_state;

  recon_ram_writer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .write_to_ram_start(start),
    .sum_0(sum[0]),   .sum_1(sum[1]),   .sum_2(sum[2]),   .sum_3(sum[3]),
    .sum_4(sum[4]),   .sum_5(sum[5]),   .sum_6(sum[6]),   .sum_7(sum[7]),
    .sum_8(sum[8]),   .sum_9(sum[9]),   .sum_10(sum[10]), .sum_11(sum[11]),
    .sum_12(sum[12]), .sum_13(sum[13]), .sum_14(sum[14]), .sum_15(sum[15]),
    .comp(comp), .blk4x4_idx(idx), .mb_x(mb_x), .mb_y(mb_y),
    .pic_width_in_mbs(width), .y_base(y_base), .cb_base(cb_base), .cr_base(cr_base),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_ack(ack), .write_to_ram_valid(valid), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  // ---------------- scoreboard state ----------------
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  acc_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int valid_pending = 0;
  int valid_seen = 0;
  int last_valid_edge = 0;
  int k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: addresses from pixel coordinates, plane rules and plain modulo arithmetic.
  function automatic void push_block();
    longint bx, by, px, py, strd, base, a;
    logic [31:0] d;
    if (comp == 2'd0) begin
      bx = 2 * idx[2] + idx[0];
      by = 2 * idx[3] + idx[1];
      px = mb_x * 16 + bx * 4;
      py = mb_y * 16 + by * 4;
      strd = 4 * width;
      base = y_base;
    end else begin
      bx = idx[0];
      by = idx[1];
      px = mb_x * 8 + bx * 4;
      py = mb_y * 8 + by * 4;
      strd = 2 * width;
      base = (comp == 2'd1) ? cb_base : cr_base;
    end
    for (int r = 0; r < 4; r++) begin
      a = (base + py * strd + px / 4 + r * strd) % (longint'(1) << AW);
      d = {sum[4*r+3], sum[4*r+2], sum[4*r+1], sum[4*r]};
      exp_q.push_back({a[AW-1:0], d});
    end
    valid_pending++;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ena) begin
        if (ram_wr_en && ack) begin
          acc_q.push_back(ram_wr_addr);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", ram_wr_addr, ram_wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(ram_wr_addr), 64'(e[AW+31:32]));
            check("wr_data", 64'(ram_wr_data), 64'(e[31:0]));
          end
        end
        if (valid) begin
          valid_seen++;
          last_valid_edge = pe + 1;
          if (valid_pending == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got pulse at edge %0d expected none", pe + 1);
          end else begin
            valid_pending--;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue();
    k = pe + 1;
    start = 1'b1;
    push_block();
    tick();
    start = 1'b0;
  endtask

  task automatic scramble();
    for (int i = 0; i < 16; i++) sum[i] = 8'($urandom);
    comp = 2'($urandom);
    idx = 4'($urandom);
    mb_x = 7'($urandom);
    mb_y = 7'($urandom);
    width = 7'($urandom);
    y_base = AW'($urandom);
    cb_base = AW'($urandom);
    cr_base = AW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int v0 = valid_seen;
    int n = 0;
    while (valid_seen == v0 && n < budget) begin
      if (rnd) begin
        ack = ($urandom_range(0, 3) != 0);
        ena = ($urandom_range(0, 7) != 0);
      end
      tick();
      n++;
    end
    n_checks++;
    if (valid_seen == v0) begin
      n_fail++;
      $display("FAIL wait_done: got no completion in %0d cycles expected one", budget);
    end
    ena = 1'b1;
    ack = 1'b1;
  endtask

  task automatic set_dir(input logic [1:0] c, input logic [3:0] ix, input logic [6:0] mx,
                         input logic [6:0] my, input logic [6:0] w);
    comp = c; idx = ix; mb_x = mx; mb_y = my; width = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    logic [AW-1:0] a_hold;
    logic [31:0] d_hold;
    for (int i = 0; i < 16; i++) sum[i] = 8'(i + 1);
    #1;
    check("reset_en", 64'(ram_wr_en), 64'd0);
    check("reset_addr", 64'(ram_wr_addr), 64'd0);
    check("reset_data", 64'(ram_wr_data), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Luma block, width 2, mb (1,0), idx 3
    set_dir(2'd0, 4'd3, 7'd1, 7'd0, 7'd2);
    y_base = '0;
    acc_q.delete();
    issue();
    scramble();
    check("y_row0_addr", 64'(ram_wr_addr), 64'd37);
    check("y_row0_data", 64'(ram_wr_data), 64'h04030201);
    wait_done(50, 1'b0);
    check("y_latency", 64'(last_valid_edge - k), 64'd5);
    check("y_nwrites", 64'(acc_q.size()), 64'd4);
    if (acc_q.size() == 4) begin
      check("y_addr1", 64'(acc_q[1]), 64'd45);
      check("y_addr3", 64'(acc_q[3]), 64'd61);
    end
    tick();

    // Cb block, width 2, mb (1,1), idx 2
    set_dir(2'd1, 4'd2, 7'd1, 7'd1, 7'd2);
    cb_base = 24'h1000;
    acc_q.delete();
    issue();
    wait_done(50, 1'b0);
    check("cb_nwrites", 64'(acc_q.size()), 64'd4);
    if (acc_q.size() == 4) begin
      check("cb_addr0", 64'(acc_q[0]), 64'h1032);
      check("cb_addr1", 64'(acc_q[1]), 64'h1036);
      check("cb_addr2", 64'(acc_q[2]), 64'h103A);
      check("cb_addr3", 64'(acc_q[3]), 64'h103E);
    end
    tick();

    // Ack withheld for three cycles while row 1 is presented
    for (int i = 0; i < 16; i++) sum[i] = 8'(i + 1);
    set_dir(2'd0, 4'd3, 7'd1, 7'd0, 7'd2);
    y_base = '0;
    acc_q.delete();
    issue();
    tick();
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 64'(ram_wr_addr), 64'd45);
      check("stall_data", 64'(ram_wr_data), 64'h08070605);
    end
    ack = 1'b1;
    wait_done(50, 1'b0);
    check("stall_latency", 64'(last_valid_edge - k), 64'd8);
    check("stall_nwrites", 64'(acc_q.size()), 64'd4);
    tick();

    // Start re-pulsed during WRITE
    scramble();
    acc_q.delete();
    v0 = valid_seen;
    issue();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done(50, 1'b0);
    repeat (8) tick();
    check("repulse_valids", 64'(valid_seen - v0), 64'd1);
    check("repulse_nwrites", 64'(acc_q.size()), 64'd4);

    // Reset after the row-1 acknowledge
    scramble();
    acc_q.delete();
    v0 = valid_seen;
    issue();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_en", 64'(ram_wr_en), 64'd0);
    check("midrst_addr", 64'(ram_wr_addr), 64'd0);
    check("midrst_data", 64'(ram_wr_data), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    if (exp_q.size() >= 2) begin
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
    end
    valid_pending--;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("midrst_novalid", 64'(valid_seen - v0), 64'd0);
    check("midrst_nwrites", 64'(acc_q.size()), 64'd2);
    scramble();
    acc_q.delete();
    issue();
    wait_done(50, 1'b0);
    check("postrst_nwrites", 64'(acc_q.size()), 64'd4);
    tick();

    // ena low for two cycles mid-WRITE with ack high
    scramble();
    acc_q.delete();
    issue();
    tick();
    ena = 1'b0;
    a_hold = ram_wr_addr;
    d_hold = ram_wr_data;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("ena_hold_addr", 64'(ram_wr_addr), 64'(a_hold));
      check("ena_hold_data", 64'(ram_wr_data), 64'(d_hold));
      check("ena_hold_en", 64'(ram_wr_en), 64'd1);
    end
    ena = 1'b1;
    wait_done(50, 1'b0);
    check("ena_latency", 64'(last_valid_edge - k), 64'd7);
    check("ena_nwrites", 64'(acc_q.size()), 64'd4);
    tick();

    // Randomized blocks with random ack stalls and enable gaps
    for (int b = 0; b < 60; b++) begin
      scramble();
      issue();
      scramble();
      wait_done(400, 1'b1);
      tick();
      tick();
    end

    repeat (4) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("valids_drained", 64'(valid_pending), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
